// File: rtl/gobang_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : gobang_pkg                                                 |
// | Description : Shared constants and types for the gobang keypad input     |
// |               conditioner: key index map and per-key FSM state codes.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package gobang_pkg;

  // Key index map; also the bit order of key_held (bit 0 = up).
  localparam int KEY_UP     = 0;
  localparam int KEY_DOWN   = 1;
  localparam int KEY_LEFT   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_OK     = 4;
  localparam int KEY_SWITCH = 5;
  localparam int NUM_KEYS   = 6;

  // Per-key press FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_HELD   = 2'd2,
    ST_REPEAT = 2'd3
  } key_state_e;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gobang_keypad_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_conditioner                                            |
// | Description : One button path: 2-flop synchroniser, counting debouncer,  |
// |               press FSM and registered single-cycle pulse output.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Config macro: GOBANG_KEY_REPEAT_EN - when defined, keys built with       |
// |               CAN_REPEAT=1 auto-repeat while held (HELD -> REPEAT).      |
// |               When undefined the repeat counter and REPEAT state are     |
// |               not built and every key pulses once per press.             |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk_slow  in  1  game clock                                            |
// |   rst       in  1  asynchronous active-low reset                         |
// |   btn_i     in  1  raw button level (already polarity-corrected)         |
// |   key_o     out 1  registered single-cycle press / repeat pulse          |
// |   held_o    out 1  debounced level, aligned with the first key_o pulse   |
// +--------------------------------------------------------------------------+
module key_conditioner
  import gobang_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 300,
  parameter int REPEAT_PERIOD   = 60,
  parameter bit CAN_REPEAT      = 1'b1
) (
  input  logic clk_slow,
  input  logic rst,
  input  logic btn_i,
  output logic key_o,
  output logic held_o
);

  // ------------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------------------
  // Debouncer: the counter tracks how many consecutive synchronised samples
  // have disagreed with the accepted level. The DEBOUNCE_CYCLES-th such
  // sample flips the level in the same edge, so the counter only ever holds
  // 0..DEBOUNCE_CYCLES-1 and cannot wrap.
  // ------------------------------------------------------------------------
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] c_deb_last = DW'(DEBOUNCE_CYCLES - 1);

  logic          deb_q;
  logic          deb_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == c_deb_last) begin
        deb_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  // ------------------------------------------------------------------------
  // Held level: the FSM needs two edges (IDLE->PRESS->HELD) to produce the
  // first pulse, so the debounced level is delayed by two flops to make
  // held_o rise with that pulse and fall the same distance after release.
  // ------------------------------------------------------------------------
  logic held_p_q;
  logic held_q;

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      held_p_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      held_p_q <= deb_q;
      held_q   <= held_p_q;
    end
  end

  assign held_o = held_q;

  // ------------------------------------------------------------------------
  // Press FSM with registered pulse output.
  // The repeat counter holds "cycles since the last pulse": it is loaded
  // with 1 on the edge that raises a pulse, so a match against N fires the
  // next pulse exactly N edges after the previous one.
  // ------------------------------------------------------------------------
`ifdef GOBANG_KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] c_rpt_delay  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] c_rpt_period = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] c_rpt_one    = RW'(1);

  logic [RW-1:0] rcnt_q;
`else
  // Repeat timing is kept on the interface for drop-in compatibility with
  // the repeat-enabled build; nothing in this build consumes it.
  if ((REPEAT_DELAY < 0) || (REPEAT_PERIOD < 0) || CAN_REPEAT) begin : g_no_repeat
  end
`endif

  key_state_e state_q;
  logic       key_q;

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= 1'b0;
`ifdef GOBANG_KEY_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      key_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (deb_q) begin
            state_q <= ST_PRESS;
          end
        end

        ST_PRESS: begin
          key_q   <= 1'b1;
          state_q <= ST_HELD;
`ifdef GOBANG_KEY_REPEAT_EN
          rcnt_q  <= c_rpt_one;
`endif
        end

        ST_HELD: begin
          if (!deb_q) begin
            state_q <= ST_IDLE;
          end
`ifdef GOBANG_KEY_REPEAT_EN
          else if (CAN_REPEAT) begin
            if (rcnt_q == c_rpt_delay) begin
              key_q   <= 1'b1;
              state_q <= ST_REPEAT;
              rcnt_q  <= c_rpt_one;
            end else if (rcnt_q != '1) begin
              rcnt_q  <= rcnt_q + 1'b1;
            end
          end
`endif
        end

`ifdef GOBANG_KEY_REPEAT_EN
        ST_REPEAT: begin
          if (!deb_q) begin
            state_q <= ST_IDLE;
          end else if (rcnt_q == c_rpt_period) begin
            key_q  <= 1'b1;
            rcnt_q <= c_rpt_one;
          end else if (rcnt_q != '1) begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
`endif

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_o = key_q;

endmodule
`default_nettype wire

// File: rtl/gobang_keypad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gobang_keypad                                              |
// | Description : Input conditioner for the six game buttons. Each button is |
// |               synchronised into clk_slow, debounced and turned into      |
// |               single-cycle key pulses for the main game FSM. Direction   |
// |               keys may auto-repeat while held.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Config macro: GOBANG_KEY_REPEAT_EN - enables auto-repeat on up, down,    |
// |               left and right. ok and switch never repeat.                |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk_slow        in  1  game clock (shared with the main game FSM)      |
// |   rst             in  1  asynchronous active-low reset                   |
// |   btn_up..switch  in  1  raw asynchronous button levels                  |
// |   key_up..switch  out 1  registered single-cycle press pulses            |
// |   key_held        out 6  debounced levels, bit 0 = up ... bit 5 = switch |
// +--------------------------------------------------------------------------+
module gobang_keypad
  import gobang_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 300,
  parameter int REPEAT_PERIOD   = 60,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic                clk_slow,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_ok,
  input  logic                btn_switch,
  output logic                key_up,
  output logic                key_down,
  output logic                key_left,
  output logic                key_right,
  output logic                key_ok,
  output logic                key_switch,
  output logic [NUM_KEYS-1:0] key_held
);

  logic [NUM_KEYS-1:0] w_btn_raw;
  logic [NUM_KEYS-1:0] w_btn;
  logic [NUM_KEYS-1:0] w_key;

  assign w_btn_raw[KEY_UP]     = btn_up;
  assign w_btn_raw[KEY_DOWN]   = btn_down;
  assign w_btn_raw[KEY_LEFT]   = btn_left;
  assign w_btn_raw[KEY_RIGHT]  = btn_right;
  assign w_btn_raw[KEY_OK]     = btn_ok;
  assign w_btn_raw[KEY_SWITCH] = btn_switch;

  // Polarity is corrected before synchronisation so everything downstream
  // sees "1 = pressed".
  assign w_btn = (BTN_ACTIVE_LOW != 0) ? ~w_btn_raw : w_btn_raw;

  // Keys are fully independent; simultaneous presses each produce their own
  // pulse and any priority is left to the consumer. Only the four direction
  // keys are built with repeat capability.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CAN_REPEAT      ((i <= KEY_RIGHT) ? 1'b1 : 1'b0)
    ) u_key (
      .clk_slow (clk_slow),
      .rst      (rst),
      .btn_i    (w_btn[i]),
      .key_o    (w_key[i]),
      .held_o   (key_held[i])
    );
  end

  assign key_up     = w_key[KEY_UP];
  assign key_down   = w_key[KEY_DOWN];
  assign key_left   = w_key[KEY_LEFT];
  assign key_right  = w_key[KEY_RIGHT];
  assign key_ok     = w_key[KEY_OK];
  assign key_switch = w_key[KEY_SWITCH];

endmodule
`default_nettype wire

// File: tb/tb_gobang_keypad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gobang_keypad                                           |
// | Description : Self-checking bench for gobang_keypad. Directed scenarios  |
// |               followed by randomized button activity, all compared each  |
// |               edge against a behavioural model of the key rules.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gobang_keypad;
  import gobang_pkg::*;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic                clk_slow = 1'b0;
  logic                rst      = 1'b0;
  logic [NUM_KEYS-1:0] btn      = '0;
  logic                key_up, key_down, key_left, key_right, key_ok, key_switch;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] w_keys;

  assign w_keys = {key_switch, key_ok, key_right, key_left, key_down, key_up};

  always #5 clk_slow = ~clk_slow;

  gobang_keypad #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER),
    .BTN_ACTIVE_LOW  (0)
  ) dut (
    .clk_slow   (clk_slow),
    .rst        (rst),
    .btn_up     (btn[KEY_UP]),
    .btn_down   (btn[KEY_DOWN]),
    .btn_left   (btn[KEY_LEFT]),
    .btn_right  (btn[KEY_RIGHT]),
    .btn_ok     (btn[KEY_OK]),
    .btn_switch (btn[KEY_SWITCH]),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_ok     (key_ok),
    .key_switch (key_switch),
    .key_held   (key_held)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt [NUM_KEYS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model, one entry per key.
  //   raw_win  : raw levels seen at recent edges (bit 0 = this edge)
  //   samp_win : levels reaching the debouncer (raw from two edges earlier)
  //   deb_hist : accepted level after the previous edge (bit 0) and the one
  //              before (bit 1)
  //   run_len  : number of consecutive edges the accepted level has been 1
  // Rules: the accepted level flips once the last DEB samples all disagree
  // with it. The first pulse comes two edges after the accepted level rises;
  // repeat pulses follow at +RDLY, then every RPER, for as long as the level
  // has stayed high up to the previous edge. key_held trails the accepted
  // level by two edges.
  // ------------------------------------------------------------------------
  logic [31:0] raw_win  [NUM_KEYS];
  logic [31:0] samp_win [NUM_KEYS];
  logic [1:0]  deb_hist [NUM_KEYS];
  int          run_len  [NUM_KEYS];

  function automatic bit repeats(input int k);
`ifdef GOBANG_KEY_REPEAT_EN
    return (k <= KEY_RIGHT);
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_KEYS; k++) begin
      raw_win[k]  = '0;
      samp_win[k] = '0;
      deb_hist[k] = '0;
      run_len[k]  = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic raw, output logic pulse, output logic held);
    int   since;
    logic flip;
    logic nlev;
    held  = deb_hist[k][1];
    since = run_len[k] - 2;
    pulse = (run_len[k] >= 2) &&
            ((since == 0) ||
             (repeats(k) && (since >= RDLY) && (((since - RDLY) % RPER) == 0)));
    raw_win[k]  = {raw_win[k][30:0], raw};
    samp_win[k] = {samp_win[k][30:0], raw_win[k][2]};
    flip = 1'b1;
    for (int j = 0; j < DEB; j++) begin
      if (samp_win[k][j] == deb_hist[k][0]) flip = 1'b0;
    end
    nlev        = deb_hist[k][0] ^ flip;
    deb_hist[k] = {deb_hist[k][0], nlev};
    run_len[k]  = nlev ? (run_len[k] + 1) : 0;
  endtask

  // One clock edge: outputs are sampled 1 time unit after the edge, the model
  // is advanced with the levels the DUT sampled at that edge.
  task automatic tick();
    logic [NUM_KEYS-1:0] ep;
    logic [NUM_KEYS-1:0] eh;
    logic p, h;
    @(posedge clk_slow);
    #1;
    for (int k = 0; k < NUM_KEYS; k++) begin
      model_edge(k, btn[k], p, h);
      ep[k] = p;
      eh[k] = h;
    end
    check_eq("keys_held", {20'd0, w_keys, key_held}, {20'd0, ep, eh});
    for (int k = 0; k < NUM_KEYS; k++) pulse_cnt[k] += int'(w_keys[k]);
  endtask

  task automatic hold(input int k, input logic v, input int n);
    btn[k] = v;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NUM_KEYS; k++) pulse_cnt[k] = 0;
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset(input int n);
    rst = 1'b0;
    #1;
    check_eq("reset_async", {20'd0, w_keys, key_held}, 32'd0);
    repeat (n) begin
      @(posedge clk_slow);
      #1;
      check_eq("reset_hold", {20'd0, w_keys, key_held}, 32'd0);
    end
    rst = 1'b1;
    model_reset();
  endtask

  int seg_left [NUM_KEYS];
  int sel;

  initial begin
    clear_counts();
    model_reset();
    repeat (3) @(posedge clk_slow);
    #1;
    check_eq("reset_state", {20'd0, w_keys, key_held}, 32'd0);
    rst = 1'b1;

    // Clean press on ok.
    clear_counts();
    hold(KEY_OK, 1'b1, 40);
    hold(KEY_OK, 1'b0, 20);
    check_eq("ok_single", pulse_cnt[KEY_OK], 1);

    // Bounce on up, then stable high.
    clear_counts();
    hold(KEY_UP, 1'b1, 1);
    hold(KEY_UP, 1'b0, 1);
    hold(KEY_UP, 1'b1, 2);
    hold(KEY_UP, 1'b0, 1);
    hold(KEY_UP, 1'b1, 20);
    hold(KEY_UP, 1'b0, 20);
    check_eq("up_bounce", pulse_cnt[KEY_UP], 1);

    // Short glitch on left.
    clear_counts();
    hold(KEY_LEFT, 1'b1, DEB - 1);
    hold(KEY_LEFT, 1'b0, 20);
    check_eq("left_glitch", pulse_cnt[KEY_LEFT], 0);

    // Right held for 30 cycles.
    clear_counts();
    hold(KEY_RIGHT, 1'b1, 30);
    hold(KEY_RIGHT, 1'b0, 20);
`ifdef GOBANG_KEY_REPEAT_EN
    check_eq("right_repeat", pulse_cnt[KEY_RIGHT], 8);
`else
    check_eq("right_repeat", pulse_cnt[KEY_RIGHT], 1);
`endif

    // Switch held for 50 cycles never repeats.
    clear_counts();
    hold(KEY_SWITCH, 1'b1, 50);
    hold(KEY_SWITCH, 1'b0, 20);
    check_eq("switch_single", pulse_cnt[KEY_SWITCH], 1);

    // Reset in the middle of a long down hold, button kept pressed.
    hold(KEY_DOWN, 1'b1, 25);
    apply_reset(3);
    clear_counts();
    hold(KEY_DOWN, 1'b1, DEB + 3);
    check_eq("down_pre_repulse", pulse_cnt[KEY_DOWN], 0);
    hold(KEY_DOWN, 1'b1, 1);
    check_eq("down_repulse", pulse_cnt[KEY_DOWN], 1);
    hold(KEY_DOWN, 1'b0, 20);

    // Randomized activity on all keys with occasional resets.
    for (int k = 0; k < NUM_KEYS; k++) seg_left[k] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (seg_left[k] == 0) begin
          btn[k] = ~btn[k];
          sel = int'($urandom_range(0, 9));
          if (sel < 3)      seg_left[k] = int'($urandom_range(1, DEB));
          else if (sel < 7) seg_left[k] = int'($urandom_range(DEB + 1, 25));
          else              seg_left[k] = int'($urandom_range(26, 60));
        end
        seg_left[k]--;
      end
      tick();
      if ($urandom_range(0, 599) == 0) apply_reset(int'($urandom_range(1, 3)));
    end

    btn = '0;
    repeat (20) tick();
    check_eq("final_idle", {20'd0, w_keys, key_held}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gobang_keypad.md
# gobang_keypad

Input conditioner for the six game buttons, directly upstream of the main game FSM. Synchronises raw push-button levels into the `clk_slow` domain, debounces them, and emits single-cycle `key_*` pulses, so one physical press produces exactly one cursor move, placement or player switch. Direction keys optionally auto-repeat while held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20: consecutive stable samples required to accept a level change.
- `REPEAT_DELAY`, default 300: held cycles after the first pulse before auto-repeat starts.
- `REPEAT_PERIOD`, default 60: cycles between auto-repeat pulses.
- `BTN_ACTIVE_LOW`, default 0: when 1, raw buttons are inverted before synchronisation.

Ports:
- `clk_slow` in 1: clock; same clock as the main game FSM.
- `rst` in 1: reset, asynchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_ok`, `btn_switch` in 1 each: raw, asynchronous button levels.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_ok`, `key_switch` out 1 each: registered single-cycle press pulses.
- `key_held` out 6: debounced level per key. Bit order: up, down, left, right, ok, switch (bit 0 = up).

## Operation
- Each key has its own path: a 2-flop synchroniser, then a debouncer, then a per-key FSM. Keys are fully independent.
- Debouncer behaviour:
  - A counter runs while the synchronised level differs from the debounced level.
  - It clears on any sample equal to the debounced level.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- Per-key FSM states:
  - IDLE: debounced level low.
  - PRESS: rising debounced edge. Pulse output for one cycle, load repeat counter, go to HELD.
  - HELD: count to `REPEAT_DELAY`, then go to REPEAT with a pulse.
  - REPEAT: pulse every `REPEAT_PERIOD` cycles.
  - From HELD or REPEAT, a debounced fall returns to IDLE with no pulse.
- `key_ok` and `key_switch` never auto-repeat. Their FSM stays in HELD until release.
- Simultaneous presses: each key pulses independently. Priority (e.g. up over down) is resolved downstream, not here.
- Counter widths are `$clog2(max+1)` of their parameter. Counters saturate and never wrap.

## Timing
- Reset values:
  - All `key_*` outputs are 0 and `key_held` is 0.
  - Synchronisers, debounced levels and counters are cleared.
  - Every FSM is in IDLE.
- A key already held when reset is released is treated as a new press. It pulses after the normal latency.
- Press latency: raw level stable high from edge 0 gives `key_x` high during the cycle after edge `DEBOUNCE_CYCLES+3`.
- Release latency: `key_held` falls `DEBOUNCE_CYCLES+3` edges after a stable raw low.
- Glitch rejection: a raw pulse or bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles produces no output change.
- Pulse width: every pulse is exactly 1 cycle. Consecutive repeat pulses are separated by `REPEAT_PERIOD-1` low cycles.
- First repeat: occurs `REPEAT_DELAY` cycles after the initial pulse.
- Reset asserted mid-press or mid-repeat clears everything immediately. No pulse is emitted during reset.

## Configuration
- Macro: `GOBANG_KEY_REPEAT_EN`.
- Defined: direction keys use HELD to REPEAT auto-repeat as above.
- Undefined:
  - The REPEAT state and repeat counters are not compiled.
  - All six keys pulse once per press only.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are accepted but unused.

## Structure
- Shared package `gobang_pkg` holds:
  - Key index constants `KEY_UP`=0, `KEY_DOWN`=1, `KEY_LEFT`=2, `KEY_RIGHT`=3, `KEY_OK`=4, `KEY_SWITCH`=5, and `NUM_KEYS`=6.
  - Per-key FSM state encodings: IDLE, PRESS, HELD, REPEAT.
- Sub-module `key_conditioner`: one key's synchroniser, debouncer, FSM and pulse register.
  - Parameter `CAN_REPEAT` selects repeat capability.
  - The top instantiates six copies: four with `CAN_REPEAT`=1 and two with `CAN_REPEAT`=0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: `btn_ok` high for 40 cycles then low → `key_ok` high exactly once, 7 edges after the press. `key_held[4]` goes high, then low 7 edges after release.
- Bounce: `btn_up` toggling 1,0,1,1,0,1 then stable high → exactly one `key_up` pulse, 7 edges after the last rising transition.
- Glitch: `btn_left` high for 3 cycles only → no `key_left` pulse; `key_held` stays 0.
- Auto-repeat (macro defined): `btn_right` held 30 cycles → pulses at the initial edge, then +10, +13, +16, +19, ... until release. With the macro undefined → single pulse only.
- Switch hold: `btn_switch` held 50 cycles → exactly one `key_switch` pulse.
- Reset mid-hold: `btn_down` held; assert `rst` low during the repeat phase → all outputs 0 at once. After release with the button still held → one fresh pulse at 7 edges.
